// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, flag bundle and FSM states.
package alu_pkg;

  localparam int unsigned OPCODE_W = 4;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_ADC = 4'b0010,
    OP_OR  = 4'b0011,
    OP_AND = 4'b0100,
    OP_XOR = 4'b0101,
    OP_NOT = 4'b0110,
    OP_SHL = 4'b0111,
    OP_SHR = 4'b1000,
    OP_ROL = 4'b1001,
    OP_ROR = 4'b1010,
    OP_SAR = 4'b1011,
    OP_SBB = 4'b1100,
    OP_MUL = 4'b1101,
    OP_CMP = 4'b1110,
    OP_MOV = 4'b1111
  } opcode_e;

  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic v;
  } flags_t;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// WIDTH cycles from start; done pulses for one cycle with prod valid.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic             r_done;

  // The start edge folds in partial product 0, so bit WIDTH-1 lands WIDTH-1 edges later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_acc    <= b[0] ? PW'(a) : '0;
        r_mcand  <= PW'(a) << 1;
        r_mplier <= b >> 1;
        r_cnt    <= CNT_W'(1);
        r_busy   <= 1'b1;
      end else if (r_busy) begin
        if (r_mplier[0]) begin
          r_acc <= r_acc + r_mcand;
        end
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign done = r_done;
  assign prod = r_acc;

endmodule

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU with persistent C/Z/N/V flags and an iterative MUL.
// Single-cycle ops complete on the accepting edge; MUL holds in_ready low.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [WIDTH-1:0]    input1,
  input  logic [WIDTH-1:0]    input2,
  output logic [WIDTH-1:0]    result,
  output logic                carryout,
  output logic                zero,
  output logic                negative,
  output logic                overflow,
  output logic                out_valid
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned W1  = WIDTH + 1;
  localparam int unsigned PW  = 2 * WIDTH;

  state_e           r_state;
  logic [WIDTH-1:0] r_result;
  flags_t           r_flags;
  logic             r_out_valid;
  logic             r_in_ready;

  state_e           w_state_nxt;
  logic [WIDTH-1:0] w_result_nxt;
  flags_t           w_flags_nxt;
  logic             w_out_valid_nxt;
  logic             w_in_ready_nxt;
  logic             w_accept;
  logic             w_mul_start;
  logic             w_mul_done;
  logic [PW-1:0]    w_mul_prod;

  opcode_e          w_op;
  logic [SHW-1:0]   w_amt;
  logic             w_amt_nz;
  logic             w_add_cin;
  logic             w_sub_bin;
  logic [W1-1:0]    w_sum;
  logic [W1-1:0]    w_diff;
  logic             w_add_v;
  logic             w_sub_v;
  logic [W1-1:0]    w_shl;
  logic [W1-1:0]    w_shr;
  logic [W1-1:0]    w_sar;
  logic [PW-1:0]    w_rol;
  logic [PW-1:0]    w_ror;
  logic [WIDTH-1:0] w_alu_res;
  logic [WIDTH-1:0] w_zn_val;
  flags_t           w_alu_flags;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (w_mul_start),
    .a     (input1),
    .b     (input2),
    .done  (w_mul_done),
    .prod  (w_mul_prod)
  );

  // Shared adder/subtractor and shifters; shifts carry an extra guard bit for carryout.
  always_comb begin
    w_op      = opcode_e'(opcode);
    w_amt     = input2[SHW-1:0];
    w_amt_nz  = |w_amt;
    w_add_cin = (w_op == OP_ADC) & r_flags.c;
    w_sub_bin = (w_op == OP_SBB) & r_flags.c;
    w_sum     = W1'(input1) + W1'(input2) + W1'(w_add_cin);
    w_diff    = W1'(input1) - W1'(input2) - W1'(w_sub_bin);
    w_add_v   = (input1[WIDTH-1] == input2[WIDTH-1]) && (w_sum[WIDTH-1] != input1[WIDTH-1]);
    w_sub_v   = (input1[WIDTH-1] != input2[WIDTH-1]) && (w_diff[WIDTH-1] != input1[WIDTH-1]);
    w_shl     = {1'b0, input1} << w_amt;
    w_shr     = {input1, 1'b0} >> w_amt;
    w_sar     = $signed({input1, 1'b0}) >>> w_amt;
    w_rol     = {input1, input1} << w_amt;
    w_ror     = {input1, input1} >> w_amt;
  end

  // Single-cycle result and flag selection.
  always_comb begin
    w_alu_res     = r_result;
    w_alu_flags   = '0;
    unique case (w_op)
      OP_ADD, OP_ADC: begin
        w_alu_res     = w_sum[WIDTH-1:0];
        w_alu_flags.c = w_sum[WIDTH];
        w_alu_flags.v = w_add_v;
      end
      OP_SUB, OP_SBB: begin
        w_alu_res     = w_diff[WIDTH-1:0];
        w_alu_flags.c = w_diff[WIDTH];
        w_alu_flags.v = w_sub_v;
      end
      OP_CMP: begin
        w_alu_flags.c = w_diff[WIDTH];
        w_alu_flags.v = w_sub_v;
      end
      OP_OR:  w_alu_res = input1 | input2;
      OP_AND: w_alu_res = input1 & input2;
      OP_XOR: w_alu_res = input1 ^ input2;
      OP_NOT: w_alu_res = ~input1;
      OP_MOV: w_alu_res = input2;
      OP_SHL: begin
        w_alu_res     = w_shl[WIDTH-1:0];
        w_alu_flags.c = w_shl[WIDTH];
      end
      OP_SHR: begin
        w_alu_res     = w_shr[WIDTH:1];
        w_alu_flags.c = w_shr[0];
      end
      OP_SAR: begin
        w_alu_res     = w_sar[WIDTH:1];
        w_alu_flags.c = w_sar[0];
      end
      OP_ROL: begin
        w_alu_res     = w_rol[PW-1:WIDTH];
        w_alu_flags.c = w_amt_nz & w_rol[WIDTH];
      end
      OP_ROR: begin
        w_alu_res     = w_ror[WIDTH-1:0];
        w_alu_flags.c = w_amt_nz & w_ror[WIDTH-1];
      end
      default: w_alu_res = r_result;
    endcase
    // CMP reports Z/N of the difference while leaving result untouched.
    w_zn_val      = (w_op == OP_CMP) ? w_diff[WIDTH-1:0] : w_alu_res;
    w_alu_flags.z = (w_zn_val == '0);
    w_alu_flags.n = w_zn_val[WIDTH-1];
  end

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_result_nxt    = r_result;
    w_flags_nxt     = r_flags;
    w_out_valid_nxt = 1'b0;
    w_in_ready_nxt  = r_in_ready;
    w_mul_start     = 1'b0;
    w_accept        = in_valid && r_in_ready;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_op == OP_MUL) begin
            w_mul_start    = 1'b1;
            w_in_ready_nxt = 1'b0;
            w_state_nxt    = ST_MUL_BUSY;
          end else begin
            w_result_nxt    = w_alu_res;
            w_flags_nxt     = w_alu_flags;
            w_out_valid_nxt = 1'b1;
          end
        end
      end
      ST_MUL_BUSY: begin
        if (w_mul_done) begin
          w_result_nxt    = w_mul_prod[WIDTH-1:0];
          w_flags_nxt.c   = |w_mul_prod[PW-1:WIDTH];
          w_flags_nxt.z   = (w_mul_prod[WIDTH-1:0] == '0);
          w_flags_nxt.n   = w_mul_prod[WIDTH-1];
          w_flags_nxt.v   = 1'b0;
          w_out_valid_nxt = 1'b1;
          w_in_ready_nxt  = 1'b1;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_result    <= '0;
      r_flags     <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_result    <= w_result_nxt;
      r_flags     <= w_flags_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_in_ready  <= w_in_ready_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign carryout  = r_flags.c;
  assign zero      = r_flags.z;
  assign negative  = r_flags.n;
  assign overflow  = r_flags.v;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: vector table of single-cycle ops plus MUL,
// reset-during-MUL and WIDTH=16 sequences.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] opcode;
  logic [7:0] input1, input2, result;
  logic       carryout, zero, negative, overflow, out_valid;

  logic        v16, rdy16, c16, z16, n16, ov16, val16;
  logic [3:0]  op16;
  logic [15:0] a16, b16, res16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .input1(input1), .input2(input2), .result(result),
    .carryout(carryout), .zero(zero), .negative(negative),
    .overflow(overflow), .out_valid(out_valid)
  );

  alu_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16),
    .opcode(op16), .input1(a16), .input2(b16), .result(res16),
    .carryout(c16), .zero(z16), .negative(n16),
    .overflow(ov16), .out_valid(val16)
  );

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c, z, n, v;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [7:0] res,
                             input logic c, input logic z, input logic n,
                             input logic v, input logic vld);
    check({tag, " result"},    32'(result),    32'(res));
    check({tag, " carryout"},  32'(carryout),  32'(c));
    check({tag, " zero"},      32'(zero),      32'(z));
    check({tag, " negative"},  32'(negative),  32'(n));
    check({tag, " overflow"},  32'(overflow),  32'(v));
    check({tag, " out_valid"}, 32'(out_valid), 32'(vld));
  endtask

  task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = op;
    input1   = a;
    input2   = b;
  endtask

  // MUL accept, 8 busy cycles with a MOV held on the bus, completion, then the MOV.
  task automatic mul_seq(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_res, input logic exp_c,
                         input logic exp_z, input logic exp_n,
                         input logic [7:0] prev_res, input logic [7:0] held_b);
    drive(4'b1101, a, b);
    @(posedge clk); #1;
    check({tag, " ready after accept"}, 32'(in_ready), 32'd0);
    check({tag, " valid after accept"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    opcode = 4'b1111;
    input2 = held_b;
    for (int i = 1; i < 8; i++) begin
      @(posedge clk); #1;
      check($sformatf("%s busy%0d in_ready", tag, i), 32'(in_ready), 32'd0);
      check($sformatf("%s busy%0d out_valid", tag, i), 32'(out_valid), 32'd0);
      check($sformatf("%s busy%0d result", tag, i), 32'(result), 32'(prev_res));
    end
    @(posedge clk); #1;
    check_state({tag, " done"}, exp_res, exp_c, exp_z, exp_n, 1'b0, 1'b1);
    check({tag, " ready at done"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check({tag, " held MOV result"}, 32'(result), 32'(held_b));
    check({tag, " held MOV valid"}, 32'(out_valid), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{4'b0000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0}; // ADD
    vecs[1]  = '{4'b0010, 8'h01, 8'h01, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0}; // ADC
    vecs[2]  = '{4'b0001, 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 1'b1, 1'b0}; // SUB
    vecs[3]  = '{4'b0000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1}; // ADD ovf
    vecs[4]  = '{4'b1110, 8'h05, 8'h05, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0}; // CMP
    vecs[5]  = '{4'b0111, 8'h81, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0}; // SHL
    vecs[6]  = '{4'b1011, 8'h80, 8'h03, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0}; // SAR
    vecs[7]  = '{4'b1010, 8'h01, 8'h01, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0}; // ROR
    vecs[8]  = '{4'b1000, 8'hA5, 8'h08, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0}; // SHR amt 0
    vecs[9]  = '{4'b0001, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0}; // SUB
    vecs[10] = '{4'b1100, 8'h05, 8'h02, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0}; // SBB
    vecs[11] = '{4'b0000, 8'hFF, 8'h02, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0}; // ADD
    vecs[12] = '{4'b0011, 8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0}; // OR
    vecs[13] = '{4'b0100, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}; // AND
    vecs[14] = '{4'b0101, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0}; // XOR
    vecs[15] = '{4'b0110, 8'h0F, 8'h00, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0}; // NOT
    vecs[16] = '{4'b1111, 8'h00, 8'h80, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0}; // MOV
    vecs[17] = '{4'b1001, 8'h81, 8'h01, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0}; // ROL
    vecs[18] = '{4'b1000, 8'h81, 8'h01, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0}; // SHR
    vecs[19] = '{4'b0001, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1}; // SUB ovf
    vecs[20] = '{4'b1110, 8'h03, 8'h05, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0}; // CMP lt
    vecs[21] = '{4'b0010, 8'h7F, 8'h00, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1}; // ADC cin

    rst = 1'b1; in_valid = 1'b0; opcode = 4'h0; input1 = 8'h00; input2 = 8'h00;
    v16 = 1'b0; op16 = 4'h0; a16 = 16'h0; b16 = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back single-cycle ops; flags chain through ADC/SBB.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      @(posedge clk); #1;
      check_state($sformatf("vec%0d", i), vecs[i].res, vecs[i].c, vecs[i].z,
                  vecs[i].n, vecs[i].v, 1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("idle out_valid", 32'(out_valid), 32'd0);
    check("idle result hold", 32'(result), 32'h80);

    mul_seq("mul1", 8'h10, 8'h20, 8'h00, 1'b1, 1'b1, 1'b0, 8'h80, 8'h5A);
    mul_seq("mul2", 8'h0D, 8'h0B, 8'h8F, 1'b0, 1'b0, 1'b1, 8'h5A, 8'h3C);

    // Put nonzero flags in place, then reset three cycles into a MUL.
    drive(4'b0001, 8'h00, 8'h01);
    @(posedge clk); #1;
    check_state("pre-rst SUB", 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(4'b1101, 8'h10, 8'h20);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_state("rst in mul", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst in mul in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("abandoned mul quiet%0d", i), 32'(out_valid), 32'd0);
    end
    drive(4'b0000, 8'h02, 8'h03);
    @(posedge clk); #1;
    check_state("post-rst ADD", 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;

    // WIDTH=16 instance: no carry out of the low byte.
    v16 = 1'b1; op16 = 4'b0000; a16 = 16'h00FF; b16 = 16'h0001;
    @(posedge clk); #1;
    check("w16 result", 32'(res16), 32'h0100);
    check("w16 carryout", 32'(c16), 32'd0);
    check("w16 zero", 32'(z16), 32'd0);
    check("w16 out_valid", 32'(val16), 32'd1);
    @(negedge clk);
    v16 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's 8-bit single-cycle ALU. It executes one operation per accepted request on WIDTH-bit operands and keeps a persistent flag register (carry, zero, negative, overflow) so carry-chained arithmetic works across requests. It also adds barrel shifts and an iterative multiplier, and sits between the register-file read stage and the writeback stage of the CPU datapath.

## Interface
- WIDTH, 8: operand/result width. Must be ≥ 4 and a power of two.
- SHW, $clog2(WIDTH): shift-amount width. Derived; do not override.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept; low only while MUL iterates.
- opcode  in  4  operation select.
- input1  in  WIDTH  operand A.
- input2  in  WIDTH  operand B; for shifts, input2[SHW-1:0] is the amount.
- result  out  WIDTH  registered result.
- carryout, zero, negative, overflow  out  1 each  registered flags.
- out_valid  out  1  one-cycle pulse when result and flags are updated.

## Operation
- A request is accepted on a rising edge where in_valid && in_ready.
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 ADC (A+B+C), 1100 SBB (A−B−C).
  - 0011 OR, 0100 AND, 0101 XOR, 0110 NOT A, 1111 MOV B.
  - 0111 SHL, 1000 SHR (logical), 1011 SAR, 1001 ROL, 1010 ROR.
  - 1101 MUL (low WIDTH bits), 1110 CMP (A−B, flags only).
- Arithmetic is computed at WIDTH+1 bits.
  - carryout is bit WIDTH of the sum for ADD/ADC.
  - carryout is the borrow (1 when A < B, with borrow-in for SBB) for SUB/SBB/CMP.
  - overflow is two's-complement signed overflow for ADD/ADC/SUB/SBB/CMP.
- Logic ops and MOV clear carryout and overflow.
- Shifts and rotates:
  - carryout = last bit shifted or rotated out; overflow cleared.
  - An amount of 0 passes A unchanged and clears carryout.
- MUL:
  - Unsigned shift-add, one partial product per cycle, WIDTH cycles.
  - carryout = 1 when the upper WIDTH bits of the full product are nonzero; overflow cleared.
- zero = (new result == 0) and negative = new result[WIDTH-1], for all ops.
  - CMP sets zero and negative from A−B but leaves result unchanged.
- Flags and result hold their value between completed operations.
- Reserved behaviour: none. All 16 opcodes are defined.
- States: IDLE and MUL_BUSY.
  - IDLE → MUL_BUSY when a MUL is accepted.
  - MUL_BUSY → IDLE after the WIDTH-th iteration, on the same edge that updates result.

## Timing
- Reset: result = 0, all four flags = 0, out_valid = 0, in_ready = 1, state = IDLE, multiplier counter = 0.
- Non-MUL op accepted at edge k: result, flags and out_valid = 1 are visible after edge k (latency 1). Back-to-back acceptance every cycle is allowed.
- MUL accepted at edge k:
  - in_ready = 0 after edges k through k+WIDTH−1.
  - Result and out_valid visible after edge k+WIDTH.
  - in_ready = 1 again after edge k+WIDTH, so a new request can be accepted on the next edge.
- in_valid while in_ready = 0 is ignored. No request is queued.
- ADC/SBB use carryout as it stands at the accepting edge, including a carry produced by the op completing on that same edge's predecessor.
- out_valid is a 1-cycle pulse; there is no downstream backpressure.
- rst during MUL_BUSY: the operation is abandoned, no out_valid is produced, and all outputs take their reset values on that edge. rst has priority over acceptance.

## Structure
- Package alu_pkg:
  - opcode enum,
  - flag struct {c, z, n, v},
  - WIDTH-independent opcode constants.
- Sub-module alu_mul_iter (WIDTH-parameterised shift-add multiplier):
  - inputs start, a, b; outputs done, prod[2*WIDTH-1:0].
  - The top level owns the FSM, the flag register and the combinational single-cycle datapath.

## Test plan
- WIDTH=8, reset, then ADD 0xFF+0x01 → result 0x00, carryout=1, zero=1, out_valid one cycle after accept. Then ADC 0x01+0x01 → 0x03.
- SUB 0x10−0x20 → 0xF0, carryout=1, negative=1, overflow=0. ADD 0x7F+0x01 → 0x80, overflow=1. CMP 0x05,0x05 → zero=1, result stays 0x80.
- SHL 0x81 by 1 → 0x02, carryout=1. SAR 0x80 by 3 → 0xF0. ROR 0x01 by 1 → 0x80, carryout=1. SHR amount 0 → A unchanged, carryout=0.
- MUL 0x10×0x20 → result 0x00, carryout=1, zero=1. in_ready low exactly 8 cycles; out_valid 8 edges after accept; a request held during busy is not accepted until in_ready returns.
- rst asserted 3 cycles into MUL → no out_valid, all outputs 0, in_ready=1 next cycle. Next ADD 0x02+0x03 → 0x05.
- Back-to-back ADD/XOR/NOT every cycle → out_valid high on three consecutive cycles with correct results. Repeat ADD 0xFF+0x01 at WIDTH=16 → 0x0100, carryout=0.
